// File: rtl/pump_valve_sequencer.sv
// rtl/pump_valve_sequencer.sv - peristaltic pump and routing-valve sequencer with abort and fail-safe closing
// Optional PUMP_SEQ_FLUSH_EN adds cmd_flush: the selected pump is held fully open for the whole PUMP phase.
module pump_valve_sequencer #(
  parameter int N_PUMPS  = 2,
  parameter int N_VALVES = 13,
  parameter int STROKE_W = 8,
  parameter int DIV_W    = 16,
  localparam int PUMP_W  = (N_PUMPS > 1) ? $clog2(N_PUMPS) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DIV_W-1:0]     cfg_div,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [PUMP_W-1:0]    cmd_pump,
  input  logic [STROKE_W-1:0]  cmd_strokes,
  input  logic                 cmd_reverse,
  input  logic [N_VALVES-1:0]  cmd_valves,
`ifdef PUMP_SEQ_FLUSH_EN
  input  logic                 cmd_flush,
`endif
  input  logic                 abort,
  output logic [3*N_PUMPS-1:0] pump_ctrl,
  output logic [N_VALVES-1:0]  valve_ctrl,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [STROKE_W-1:0]  stroke_cnt
);

  typedef enum logic [2:0] {ST_IDLE, ST_SETTLE, ST_PUMP, ST_HOLD, ST_DONE} state_t;

  state_t              state;
  logic [DIV_W-1:0]    div_q;
  logic [DIV_W-1:0]    timer;
  logic [STROKE_W-1:0] strokes_q;
  logic [PUMP_W-1:0]   sel_q;
  logic [2:0]          phase_idx;
  logic [2:0]          phase_cnt;
  logic [2:0]          next_idx;
  logic                rev_q;
  logic                err_q;
  logic                flush_q;
  logic                phase_end;

  function automatic logic [2:0] phase_bits(input logic [2:0] idx, input logic flush);
    logic [2:0] b;
    case (idx)
      3'd0:    b = 3'b110;
      3'd1:    b = 3'b100;
      3'd2:    b = 3'b101;
      3'd3:    b = 3'b001;
      3'd4:    b = 3'b011;
      3'd5:    b = 3'b010;
      default: b = 3'b111;
    endcase
    return flush ? 3'b000 : b;
  endfunction

  // An out-of-range selector matches no pump, so every pump stays closed.
  function automatic logic [3*N_PUMPS-1:0] pump_vec(input logic [PUMP_W-1:0] sel, input logic [2:0] bits);
    logic [3*N_PUMPS-1:0] v;
    v = '1;
    for (int k = 0; k < N_PUMPS; k++) begin
      if (sel == PUMP_W'(k)) v[3*k +: 3] = bits;
    end
    return v;
  endfunction

  assign phase_end = (timer == div_q - DIV_W'(1));

  always_comb begin
    next_idx = 3'd0;
    if (rev_q) next_idx = (phase_idx == 3'd0) ? 3'd5 : phase_idx - 3'd1;
    else       next_idx = (phase_idx == 3'd5) ? 3'd0 : phase_idx + 3'd1;
  end

`ifndef PUMP_SEQ_FLUSH_EN
  assign flush_q = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      div_q      <= DIV_W'(1);
      timer      <= '0;
      strokes_q  <= '0;
      sel_q      <= '0;
      phase_idx  <= '0;
      phase_cnt  <= '0;
      rev_q      <= 1'b0;
      err_q      <= 1'b0;
`ifdef PUMP_SEQ_FLUSH_EN
      flush_q    <= 1'b0;
`endif
      pump_ctrl  <= '1;
      valve_ctrl <= '0;
      cmd_ready  <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      stroke_cnt <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            div_q      <= (cfg_div == '0) ? DIV_W'(1) : cfg_div;
            timer      <= '0;
            strokes_q  <= cmd_strokes;
            sel_q      <= cmd_pump;
            rev_q      <= cmd_reverse;
            phase_idx  <= cmd_reverse ? 3'd5 : 3'd0;
            phase_cnt  <= '0;
            err_q      <= (int'(cmd_pump) >= N_PUMPS);
`ifdef PUMP_SEQ_FLUSH_EN
            flush_q    <= cmd_flush;
`endif
            stroke_cnt <= '0;
            valve_ctrl <= cmd_valves;
            pump_ctrl  <= '1;
            cmd_ready  <= 1'b0;
            busy       <= 1'b1;
            state      <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (abort) begin
            err_q <= 1'b1;
            timer <= '0;
            state <= ST_HOLD;
          end else if (phase_end) begin
            timer <= '0;
            if (strokes_q == '0) begin
              state <= ST_HOLD;
            end else begin
              pump_ctrl <= pump_vec(sel_q, phase_bits(phase_idx, flush_q));
              state     <= ST_PUMP;
            end
          end else begin
            timer <= timer + DIV_W'(1);
          end
        end
        ST_PUMP: begin
          if (abort) begin
            err_q     <= 1'b1;
            timer     <= '0;
            pump_ctrl <= '1;
            state     <= ST_HOLD;
          end else if (phase_end) begin
            timer <= '0;
            if (phase_cnt == 3'd5 && stroke_cnt + STROKE_W'(1) == strokes_q) begin
              stroke_cnt <= stroke_cnt + STROKE_W'(1);
              pump_ctrl  <= '1;
              state      <= ST_HOLD;
            end else begin
              if (phase_cnt == 3'd5) begin
                phase_cnt  <= '0;
                stroke_cnt <= stroke_cnt + STROKE_W'(1);
              end else begin
                phase_cnt <= phase_cnt + 3'd1;
              end
              phase_idx <= next_idx;
              pump_ctrl <= pump_vec(sel_q, phase_bits(next_idx, flush_q));
            end
          end else begin
            timer <= timer + DIV_W'(1);
          end
        end
        ST_HOLD: begin
          if (phase_end) begin
            timer      <= '0;
            done       <= 1'b1;
            err        <= err_q;
            valve_ctrl <= '0;
            state      <= ST_DONE;
          end else begin
            timer <= timer + DIV_W'(1);
          end
        end
        ST_DONE: begin
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
